// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the BTB-based branch predictor.
package branch_predictor_pkg;

    // Upper bounds for the per-entry fields; instances use the low bits.
    localparam int unsigned PC_W_MAX  = 32;
    localparam int unsigned CTR_W_MAX = 4;

    localparam int unsigned MODE_STATIC  = 0;
    localparam int unsigned MODE_DYNAMIC = 1;

    typedef struct packed {
        logic                 valid;
        logic [PC_W_MAX-1:0]  tag;
        logic [PC_W_MAX-1:0]  target;
        logic [CTR_W_MAX-1:0] ctr;
    } btb_entry_t;

    // Weakly-taken counter value: MSB set, all other bits clear.
    function automatic logic [CTR_W_MAX-1:0] CTR_WEAK_T(input int unsigned ctr_w);
        return CTR_W_MAX'(1) << (ctr_w - 1);
    endfunction

    // Weakly-not-taken counter value: one below weakly-taken.
    function automatic logic [CTR_W_MAX-1:0] CTR_WEAK_NT(input int unsigned ctr_w);
        return CTR_WEAK_T(ctr_w) - CTR_W_MAX'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, decode-stage training and flush/statistics signals.
interface branch_predictor_if #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned CNT_W = 32
);
    logic             enable;
    logic [PC_W-1:0]  fetch_pc;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic             pred_hit;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic [PC_W-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [PC_W-1:0]  upd_pred_target;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] lookup_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output enable, fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, pred_hit, mispredict, redirect_pc,
               lookup_count, mispredict_count
    );

    modport slave (
        input  enable, fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, pred_hit, mispredict, redirect_pc,
               lookup_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Up/down saturating next-value function for the per-entry counters.
module sat_counter #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] value,
    input  logic         inc,
    output logic [W-1:0] result
);

    // Step towards all-ones on inc, towards zero otherwise, holding at the rails.
    always_comb begin
        result = value;
        if (inc) begin
            if (value != '1) result = value + W'(1);
        end else begin
            if (value != '0) result = value - W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters; zero-latency lookup for fetch,
// trained by decode, with mispredict detection and update statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned MODE    = MODE_DYNAMIC,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W;

    // Register array so the fetch lookup has no read latency.
    btb_entry_t btb [ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             train;
    logic [CTR_W-1:0] ctr_next;
    logic [CNT_W-1:0] lookup_q;
    logic [CNT_W-1:0] misp_q;

    assign fetch_idx = bus.fetch_pc[IDX_W-1:0];
    assign fetch_tag = bus.fetch_pc[PC_W-1:IDX_W];
    assign upd_idx   = bus.upd_pc[IDX_W-1:0];
    assign upd_tag   = bus.upd_pc[PC_W-1:IDX_W];

    // Fetch-side prediction; static mode never reports a hit.
    assign bus.pred_hit    = (MODE == MODE_DYNAMIC) && btb[fetch_idx].valid
                             && (btb[fetch_idx].tag == PC_W_MAX'(fetch_tag));
    assign bus.pred_taken  = bus.pred_hit && btb[fetch_idx].ctr[CTR_W-1];
    assign bus.pred_target = bus.pred_taken ? PC_W'(btb[fetch_idx].target)
                                            : bus.fetch_pc + PC_W'(1);

    // Flush request and corrected PC straight from the resolving instruction.
    assign bus.mispredict  = bus.upd_valid
                             && ((bus.upd_taken != bus.upd_pred_taken)
                                 || (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
    assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + PC_W'(1);

    assign upd_hit = btb[upd_idx].valid && (btb[upd_idx].tag == PC_W_MAX'(upd_tag));
    assign train   = bus.upd_valid && bus.enable && (MODE == MODE_DYNAMIC);

    sat_counter #(.W(CTR_W)) u_sat_counter (
        .value  (CTR_W'(btb[upd_idx].ctr)),
        .inc    (bus.upd_taken),
        .result (ctr_next)
    );

    // Table training: bump counter on hit, allocate weakly-taken on taken miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT(CTR_W)};
            end
        end else if (train) begin
            if (upd_hit) begin
                btb[upd_idx].ctr <= CTR_W_MAX'(ctr_next);
                if (bus.upd_taken) btb[upd_idx].target <= PC_W_MAX'(bus.upd_target);
            end else if (bus.upd_taken) begin
                btb[upd_idx] <= '{valid:  1'b1,
                                  tag:    PC_W_MAX'(upd_tag),
                                  target: PC_W_MAX'(bus.upd_target),
                                  ctr:    CTR_WEAK_T(CTR_W)};
            end
        end
    end

    // Saturating update and mispredict statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_q <= '0;
            misp_q   <= '0;
        end else if (bus.upd_valid && bus.enable) begin
            if (lookup_q != '1) lookup_q <= lookup_q + CNT_W'(1);
            if (bus.mispredict && (misp_q != '1)) misp_q <= misp_q + CNT_W'(1);
        end
    end

    assign bus.lookup_count     = lookup_q;
    assign bus.mispredict_count = misp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed checks of branch_predictor against a table model.
module tb_branch_predictor;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned CTR_W   = 2;
    localparam int unsigned CNT_W   = 32;
    localparam int PC_MOD  = 256;
    localparam int CTR_MAX = 3;
    localparam int CTR_WT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    branch_predictor_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bif ();
    branch_predictor_if #(.PC_W(PC_W), .CNT_W(CNT_W)) sif ();

    // Static-mode instance sees the same stimulus as the dynamic one.
    assign sif.enable          = bif.enable;
    assign sif.fetch_pc        = bif.fetch_pc;
    assign sif.upd_valid       = bif.upd_valid;
    assign sif.upd_pc          = bif.upd_pc;
    assign sif.upd_taken       = bif.upd_taken;
    assign sif.upd_target      = bif.upd_target;
    assign sif.upd_pred_taken  = bif.upd_pred_taken;
    assign sif.upd_pred_target = bif.upd_pred_target;

    branch_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .MODE(1), .CNT_W(CNT_W))
        dut (.clk(clk), .rst(rst), .bus(bif.slave));

    branch_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .MODE(0), .CNT_W(CNT_W))
        sdut (.clk(clk), .rst(rst), .bus(sif.slave));

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: one record per BTB slot, counters as plain integers.
    int     mv   [ENTRIES];
    int     mtag [ENTRIES];
    int     mtgt [ENTRIES];
    int     mctr [ENTRIES];
    longint m_lookups;
    longint m_misp;

    // Stimulus values for the current cycle.
    int f_pc, u_pc, u_target, u_ptarget;
    bit u_valid, u_taken, u_ptaken, u_en;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mctr[i] = CTR_WT - 1;
        end
        m_lookups = 0;
        m_misp    = 0;
    endfunction

    function automatic bit m_hit(input int pc);
        return (mv[pc % ENTRIES] != 0) && (mtag[pc % ENTRIES] == pc / ENTRIES);
    endfunction

    function automatic bit m_taken(input int pc);
        return m_hit(pc) && (mctr[pc % ENTRIES] >= CTR_WT);
    endfunction

    function automatic int m_target(input int pc);
        return m_taken(pc) ? mtgt[pc % ENTRIES] : (pc + 1) % PC_MOD;
    endfunction

    function automatic bit m_misp_now();
        return u_valid && ((u_taken != u_ptaken) || (u_taken && (u_target != u_ptarget)));
    endfunction

    function automatic void model_update(input bit mp);
        int i;
        i = u_pc % ENTRIES;
        m_lookups++;
        if (mp) m_misp++;
        if (m_hit(u_pc)) begin
            mctr[i] = u_taken ? ((mctr[i] + 1 > CTR_MAX) ? CTR_MAX : mctr[i] + 1)
                              : ((mctr[i] - 1 < 0) ? 0 : mctr[i] - 1);
            if (u_taken) mtgt[i] = u_target;
        end else if (u_taken) begin
            mv[i] = 1; mtag[i] = u_pc / ENTRIES; mtgt[i] = u_target; mctr[i] = CTR_WT;
        end
    endfunction

    task automatic drive();
        bif.fetch_pc        = 8'(f_pc);
        bif.enable          = u_en;
        bif.upd_valid       = u_valid;
        bif.upd_pc          = 8'(u_pc);
        bif.upd_taken       = u_taken;
        bif.upd_target      = 8'(u_target);
        bif.upd_pred_taken  = u_ptaken;
        bif.upd_pred_target = 8'(u_ptarget);
    endtask

    task automatic set_upd(input bit v, input int pc, input bit t, input int tg,
                           input bit pt, input int ptg);
        u_valid = v; u_pc = pc; u_taken = t; u_target = tg; u_ptaken = pt; u_ptarget = ptg;
    endtask

    // Check all outputs against the model, then advance one clock edge.
    task automatic step();
        bit mp;
        drive();
        #1;
        mp = m_misp_now();
        check_eq("pred_hit",    bif.pred_hit,    m_hit(f_pc));
        check_eq("pred_taken",  bif.pred_taken,  m_taken(f_pc));
        check_eq("pred_target", bif.pred_target, m_target(f_pc));
        check_eq("mispredict",  bif.mispredict,  mp);
        check_eq("redirect_pc", bif.redirect_pc, u_taken ? u_target : (u_pc + 1) % PC_MOD);
        check_eq("lookup_count",     bif.lookup_count,     m_lookups);
        check_eq("mispredict_count", bif.mispredict_count, m_misp);
        check_eq("static_hit",    sif.pred_hit,    0);
        check_eq("static_taken",  sif.pred_taken,  0);
        check_eq("static_target", sif.pred_target, (f_pc + 1) % PC_MOD);
        check_eq("static_misp",   sif.mispredict,  mp);
        check_eq("static_lookups", sif.lookup_count, m_lookups);
        @(posedge clk);
        if (rst) model_reset();
        else if (u_valid && u_en) model_update(mp);
        #1;
    endtask

    function automatic int pick_pc();
        int pool [8] = '{8'h02, 8'h12, 8'h22, 8'h05, 8'h15, 8'h0A, 8'hFF, 8'h3F};
        return ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)]
                                           : int'($urandom_range(0, 255));
    endfunction

    initial begin
        longint misp_before;
        model_reset();
        f_pc = 8'h05; u_en = 1;
        set_upd(0, 0, 0, 0, 0, 0);
        drive();
        @(posedge clk); #1;

        // Reset state.
        step(); step();
        rst = 1'b0;
        step();
        check_eq("rst_hit",    bif.pred_hit,    0);
        check_eq("rst_taken",  bif.pred_taken,  0);
        check_eq("rst_target", bif.pred_target, 8'h06);
        check_eq("rst_lookups", bif.lookup_count, 0);

        // Allocation on a taken miss.
        set_upd(1, 8'h12, 1, 8'h30, 0, 8'h13);
        drive(); #1;
        check_eq("alloc_misp",     bif.mispredict,  1);
        check_eq("alloc_redirect", bif.redirect_pc, 8'h30);
        step();
        set_upd(0, 0, 0, 0, 0, 0);
        f_pc = 8'h12;
        drive(); #1;
        check_eq("alloc_hit",    bif.pred_hit,    1);
        check_eq("alloc_taken",  bif.pred_taken,  1);
        check_eq("alloc_target", bif.pred_target, 8'h30);
        step();

        // Saturation up then down.
        for (int k = 0; k < 4; k++) begin
            set_upd(1, 8'h12, 1, 8'h30, 1, 8'h30); step();
        end
        for (int k = 0; k < 3; k++) begin
            set_upd(1, 8'h12, 0, 8'h30, 1, 8'h30); step();
        end
        set_upd(0, 0, 0, 0, 0, 0);
        drive(); #1;
        check_eq("sat_hit",    bif.pred_hit,    1);
        check_eq("sat_taken",  bif.pred_taken,  0);
        check_eq("sat_target", bif.pred_target, 8'h13);
        step();

        // Aliasing between 0x02 and 0x12.
        set_upd(1, 8'h02, 1, 8'h50, 0, 8'h03); step();
        set_upd(0, 0, 0, 0, 0, 0);
        drive(); #1;
        check_eq("alias_evict_12", bif.pred_hit, 0);
        step();
        set_upd(1, 8'h12, 1, 8'h30, 0, 8'h13); f_pc = 8'h02; step();
        set_upd(0, 0, 0, 0, 0, 0);
        drive(); #1;
        check_eq("alias_evict_02", bif.pred_hit, 0);
        step();

        // Wrong target with correct direction.
        misp_before = m_misp;
        set_upd(1, 8'h12, 1, 8'h40, 1, 8'h30);
        drive(); #1;
        check_eq("wt_misp",     bif.mispredict,  1);
        check_eq("wt_redirect", bif.redirect_pc, 8'h40);
        step();
        set_upd(0, 0, 0, 0, 0, 0);
        drive(); #1;
        check_eq("wt_count", bif.mispredict_count, misp_before + 1);
        step();

        // Hold: enable low blocks training and statistics.
        u_en = 0; f_pc = 8'h05;
        set_upd(1, 8'h05, 1, 8'h77, 0, 8'h06); step();
        set_upd(0, 0, 0, 0, 0, 0); u_en = 1;
        drive(); #1;
        check_eq("hold_hit", bif.pred_hit, 0);
        step();

        // Static-mode wrap of the sequential target.
        f_pc = 8'hFF;
        drive(); #1;
        check_eq("static_wrap", sif.pred_target, 8'h00);
        step();

        // Reset raised while an update is presented discards it.
        f_pc = 8'h22;
        set_upd(1, 8'h22, 1, 8'h44, 0, 8'h23);
        rst = 1'b1; model_reset();
        step();
        rst = 1'b0;
        set_upd(0, 0, 0, 0, 0, 0);
        drive(); #1;
        check_eq("rst_upd_hit", bif.pred_hit, 0);
        step();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            f_pc  = pick_pc();
            u_en  = ($urandom_range(0, 9) != 0);
            u_pc  = pick_pc();
            u_valid  = ($urandom_range(0, 9) < 7);
            u_taken  = $urandom_range(0, 1);
            u_target = ($urandom_range(0, 1) == 0) ? 8'h30 : int'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                u_ptaken  = m_taken(u_pc);
                u_ptarget = m_target(u_pc);
            end else begin
                u_ptaken  = $urandom_range(0, 1);
                u_ptarget = $urandom_range(0, 255);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the pipelined core. It replaces the current fixed predict-not-taken fetch path with a direct-mapped branch target buffer (BTB) and per-entry saturating counters. The predictor is looked up combinationally by the fetch stage. It is trained by the decode stage when a branch or jump resolves, and it reports mispredicts so the hazard unit can flush IF/ID and redirect the PC.

## Interface
- `PC_W`, default 8: PC / instruction-address width.
- `ENTRIES`, default 16: number of BTB entries; power of two, 2..256. `IDX_W = log2(ENTRIES)`, `TAG_W = PC_W - IDX_W`.
- `CTR_W`, default 2: saturating-counter width, 1..4.
- `MODE`, default 1: 0 = static predict-not-taken (table never consulted or written); 1 = dynamic.
- `CNT_W`, default 32: width of the statistics counters.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  global hold; when low, no table write and no statistics change.
- `fetch_pc`  in  PC_W  address being fetched.
- `pred_taken`  out  1  prediction for `fetch_pc`.
- `pred_target`  out  PC_W  next fetch address: BTB target if `pred_taken`, else `fetch_pc+1`.
- `pred_hit`  out  1  BTB tag match for `fetch_pc`.
- `upd_valid`  in  1  decode-stage control-flow instruction resolving this cycle.
- `upd_pc`  in  PC_W  address of the resolving instruction.
- `upd_taken`  in  1  actual outcome.
- `upd_target`  in  PC_W  actual target.
- `upd_pred_taken`  in  1  prediction carried down through IF/ID.
- `upd_pred_target`  in  PC_W  predicted next address carried down through IF/ID.
- `mispredict`  out  1  flush request.
- `redirect_pc`  out  PC_W  corrected PC; valid when `mispredict` is high.
- `lookup_count`  out  CNT_W  number of update events.
- `mispredict_count`  out  CNT_W  number of mispredicts.

## Operation
- Entry fields: `valid`, `tag[TAG_W]`, `target[PC_W]`, `ctr[CTR_W]`.
- Index is `pc[IDX_W-1:0]`; tag is `pc[PC_W-1:IDX_W]`.
- **Lookup (combinational):**
  - `pred_hit = valid & tag match`.
  - `pred_taken = pred_hit & ctr[CTR_W-1]`.
  - `MODE=0`: `pred_hit` and `pred_taken` are 0.
- **Mispredict (combinational):** `mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target))`.
- **Redirect:** `redirect_pc = upd_taken ? upd_target : upd_pc+1`.
- **Training**, on a clock edge with `upd_valid & enable & MODE=1`:
  - Hit: counter +1 if taken, −1 if not; saturates at all-ones and zero. Target is overwritten when taken.
  - Miss and taken: allocate the entry (overwrite): `valid=1`, tag, target, `ctr = 2^(CTR_W-1)` (weakly taken).
  - Miss and not taken: no change.
- **Statistics:** on `upd_valid & enable`, `lookup_count` increments. `mispredict_count` also increments if `mispredict`. Both saturate at all-ones.

## Timing
- Prediction has zero-cycle latency from `fetch_pc`. A table write becomes visible to lookups the cycle after the edge.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update entry.
- `mispredict` and `redirect_pc` are purely combinational from the `upd_*` inputs.
- PC arithmetic wraps modulo 2^PC_W: `fetch_pc = all-ones` gives `pred_target = 0`.
- **Reset:**
  - All `valid` bits cleared; all `ctr = 2^(CTR_W-1)-1` (weakly not-taken); targets and tags 0.
  - Statistics counters 0.
  - Outputs during reset: `pred_hit=0`, `pred_taken=0`, `pred_target=fetch_pc+1`.
  - Reset asserted mid-update discards that update.
- `enable` low freezes all state; the combinational outputs are still driven.

## Structure
- The shared package holds:
  - `CTR_WEAK_T(CTR_W)` and `CTR_WEAK_NT(CTR_W)` constant functions.
  - The BTB entry struct typedef.
  - The `MODE_STATIC` and `MODE_DYNAMIC` constants.
- One sub-module, `sat_counter`: a `CTR_W`-bit up/down saturating next-value function (combinational), instantiated once on the update path.
- The table is a register array, not the synchronous IP RAM, because the lookup must be zero-latency.

## Test plan
- **Reset state:** reset, then `fetch_pc=0x05` → `pred_hit=0`, `pred_taken=0`, `pred_target=0x06`; both counts 0.
- **Allocation:** update `upd_pc=0x12`, taken, target `0x30`, `upd_pred_taken=0` → `mispredict=1`, `redirect_pc=0x30`. Next cycle `fetch_pc=0x12` → `hit=1`, `taken=1`, `pred_target=0x30`.
- **Saturation (CTR_W=2):** four taken updates on `0x12` → ctr=3. Then three not-taken updates → ctr=0, `pred_taken=0`, `pred_target=0x13`.
- **Aliasing (ENTRIES=16):** `0x02` and `0x12` alternate taken updates → each allocation evicts the other; lookup of the non-resident address gives `hit=0`.
- **Wrong target:** `upd_taken=1`, `upd_pred_taken=1`, `upd_pred_target=0x30`, `upd_target=0x40` → `mispredict=1`, `redirect_pc=0x40`; `mispredict_count` +1.
- **Hold and static mode:** `enable=0` with `upd_valid` → no state or count change. Separately, `MODE=0` → `pred_taken` always 0 and wrap case `fetch_pc=0xFF` → `pred_target=0x00`.
